// File: rtl/pte_cache_pkg.sv
// Shared defaults, FSM state encoding and entry layout for the page-table-walker PTE cache.
package pte_cache_pkg;

    localparam int DEF_ENTRIES = 8;
    localparam int DEF_TAG_W   = 27;
    localparam int DEF_PPN_W   = 20;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        MISS,
        RESP
    } pte_state_e;

    typedef struct packed {
        logic                 valid;
        logic [DEF_TAG_W-1:0] tag;
        logic [DEF_PPN_W-1:0] ppn;
    } pte_cache_entry_t;

endpackage

// File: rtl/pte_cache_victim_sel.sv
// Victim picker: lowest invalid entry first, otherwise round-robin pointer (or tree PLRU with PTE_CACHE_PLRU_EN).
// Latency: combinational victim from registered state; pointer/tree update on the clock edge of an install or hit.
// Backpressure: none, purely follows the controller's install/hit strobes.
module pte_cache_victim_sel #(
    parameter int  ENTRIES = 8,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ENTRIES-1:0] i_valid,
    input  logic               i_install,
    input  logic               i_hit,
    input  logic [IDX_W-1:0]   i_hit_idx,
    output logic [IDX_W-1:0]   o_replace_entry
);

    logic             w_any_inv;
    logic [IDX_W-1:0] w_inv_idx;
    logic [IDX_W-1:0] w_full_idx;

    always_comb begin
        w_any_inv = 1'b0;
        w_inv_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!i_valid[i]) begin
                w_any_inv = 1'b1;
                w_inv_idx = IDX_W'(i);
            end
        end
    end

`ifdef PTE_CACHE_PLRU_EN
    logic [ENTRIES-2:0] r_tree;
    logic [ENTRIES-2:0] w_tree_nxt;
    logic               w_touch;
    logic [IDX_W-1:0]   w_touch_idx;

    // Heap-ordered tree: node n has children 2n+1 / 2n+2; a 0 bit points left at the victim.
    always_comb begin : p_plru_victim
        int node;
        node       = 0;
        w_full_idx = '0;
        for (int l = 0; l < IDX_W; l++) begin
            w_full_idx[IDX_W-1-l] = r_tree[node];
            node = 2 * node + 1 + int'(r_tree[node]);
        end
    end

    assign w_touch     = i_hit | i_install;
    assign w_touch_idx = i_hit ? i_hit_idx : o_replace_entry;

    always_comb begin : p_plru_update
        int node;
        node       = 0;
        w_tree_nxt = r_tree;
        for (int l = 0; l < IDX_W; l++) begin
            w_tree_nxt[node] = ~w_touch_idx[IDX_W-1-l];
            node = 2 * node + 1 + int'(w_touch_idx[IDX_W-1-l]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tree <= '0;
        end else if (w_touch) begin
            r_tree <= w_tree_nxt;
        end
    end
`else
    logic [IDX_W-1:0] r_rr_ptr;
    logic             w_unused_plru;

    // Advance only when the install displaced a live entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (i_install && !w_any_inv) begin
            r_rr_ptr <= r_rr_ptr + IDX_W'(1);
        end
    end

    assign w_full_idx    = r_rr_ptr;
    assign w_unused_plru = ^{i_hit, i_hit_idx};
`endif

    assign o_replace_entry = w_any_inv ? w_inv_idx : w_full_idx;

endmodule

// File: rtl/pte_cache_ctrl.sv
// PTE cache controller: one lookup at a time, walk on miss, install into victim (PTE_CACHE_PLRU_EN selects PLRU).
// Latency: hit response 2 cycles after accept; miss response 1 cycle after refill_valid.
// Backpressure: response held until rsp_ready; lk_ready low while any lookup is in flight or flush is high.
module pte_cache_ctrl
    import pte_cache_pkg::*;
#(
    parameter int  ENTRIES = DEF_ENTRIES,
    parameter int  TAG_W   = DEF_TAG_W,
    parameter int  PPN_W   = DEF_PPN_W,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     lk_valid,
    output logic                     lk_ready,
    input  logic [TAG_W-1:0]         lk_tag,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_hit,
    output logic                     rsp_err,
    output logic [PPN_W-1:0]         rsp_ppn,
    output logic                     miss_valid,
    output logic [TAG_W-1:0]         miss_tag,
    input  logic                     refill_valid,
    input  logic                     refill_err,
    input  logic [PPN_W-1:0]         refill_ppn,
    input  logic                     flush,
    output logic [ENTRIES-1:0]       hit_bit,
    output logic [IDX_W-1:0]         replace_entry,
    output logic [ENTRIES*PPN_W-1:0] ppn_array
);

    pte_state_e         r_state;
    pte_state_e         w_state_nxt;
    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag [ENTRIES];
    logic [PPN_W-1:0]   r_ppn [ENTRIES];
    logic [TAG_W-1:0]   r_lk_tag;
    logic               r_drop;
    logic [PPN_W-1:0]   r_rsp_ppn;
    logic               r_rsp_hit;
    logic               r_rsp_err;

    logic [ENTRIES-1:0] w_match;
    logic [IDX_W-1:0]   w_hit_idx;
    logic               w_accept;
    logic               w_lookup_hit;
    logic               w_refill;
    logic               w_install;
    logic [IDX_W-1:0]   w_victim;

    // Tags are unique, so OR-ing matching indices yields the single hit index.
    always_comb begin
        w_match   = '0;
        w_hit_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (r_valid[i] && (r_tag[i] == r_lk_tag)) begin
                w_match[i] = 1'b1;
                w_hit_idx  = w_hit_idx | IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        lk_ready    = 1'b0;
        rsp_valid   = 1'b0;
        miss_valid  = 1'b0;
        hit_bit     = '0;
        case (r_state)
            IDLE: begin
                lk_ready = !flush;
                if (lk_valid && !flush) w_state_nxt = LOOKUP;
            end
            LOOKUP: begin
                hit_bit     = w_match;
                w_state_nxt = (|w_match) ? RESP : MISS;
            end
            MISS: begin
                miss_valid = 1'b1;
                if (refill_valid) w_state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_accept     = lk_valid && lk_ready;
    assign w_lookup_hit = (r_state == LOOKUP) && (|w_match);
    assign w_refill     = (r_state == MISS) && refill_valid;
    // A flush on the refill cycle also suppresses the install.
    assign w_install    = w_refill && !refill_err && !r_drop && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= '0;
            r_lk_tag  <= '0;
            r_drop    <= 1'b0;
            r_rsp_ppn <= '0;
            r_rsp_hit <= 1'b0;
            r_rsp_err <= 1'b0;
        end else begin
            if (w_accept) r_lk_tag <= lk_tag;

            if (flush) begin
                r_valid <= '0;
            end else if (w_install) begin
                r_valid[w_victim] <= 1'b1;
            end

            if ((r_state == RESP) && rsp_ready) begin
                r_drop <= 1'b0;
            end else if (flush && (r_state == MISS)) begin
                r_drop <= 1'b1;
            end

            if (w_lookup_hit) begin
                r_rsp_ppn <= r_ppn[w_hit_idx];
                r_rsp_hit <= 1'b1;
                r_rsp_err <= 1'b0;
            end else if (w_refill) begin
                r_rsp_ppn <= refill_err ? '0 : refill_ppn;
                r_rsp_hit <= 1'b0;
                r_rsp_err <= refill_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_install) begin
            r_tag[w_victim] <= r_lk_tag;
            r_ppn[w_victim] <= refill_ppn;
        end
    end

    pte_cache_victim_sel #(
        .ENTRIES (ENTRIES)
    ) u_victim_sel (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_valid         (r_valid),
        .i_install       (w_install),
        .i_hit           (w_lookup_hit),
        .i_hit_idx       (w_hit_idx),
        .o_replace_entry (w_victim)
    );

    always_comb begin
        ppn_array = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            ppn_array[i*PPN_W +: PPN_W] = r_ppn[i];
        end
    end

    assign replace_entry = w_victim;
    assign miss_tag      = r_lk_tag;
    assign rsp_ppn       = r_rsp_ppn;
    assign rsp_hit       = r_rsp_hit;
    assign rsp_err       = r_rsp_err;

endmodule

// File: doc/pte_cache_ctrl.md
Name: pte_cache_ctrl

Overview:
- Sequencing and replacement controller for the 8-entry fully-associative PTE cache used by the page-table walker.
- Owns the tag, valid and PPN arrays. Accepts one lookup at a time from the walker front end and compares the tag against all valid entries.
- On a miss, requests a memory walk, installs the returned PPN into a victim entry and responds.
- Exports per-entry hit vector, replace index and PPN array to the PTE cache data-select datapath.

Parameters:
- ENTRIES, 8, number of cache entries; power of two, ≥2.
- TAG_W, 27, lookup tag width (VPN bits plus level).
- PPN_W, 20, stored PPN width.
- IDX_W, $clog2(ENTRIES), entry index width (derived, not overridden).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- lk_valid  in  1  lookup request
- lk_ready  out  1  controller can accept a lookup
- lk_tag  in  TAG_W  lookup tag
- rsp_valid  out  1  response available
- rsp_ready  in  1  requester accepts response
- rsp_hit  out  1  response came from a cache hit
- rsp_err  out  1  walk returned an error
- rsp_ppn  out  PPN_W  response PPN
- miss_valid  out  1  walk request to memory side
- miss_tag  out  TAG_W  tag being walked
- refill_valid  in  1  walk result valid (single-cycle pulse)
- refill_err  in  1  walk faulted
- refill_ppn  in  PPN_W  walk result PPN
- flush  in  1  invalidate all entries (sfence.vma)
- hit_bit  out  ENTRIES  one-hot hit vector for the datapath
- replace_entry  out  IDX_W  current victim index for the datapath
- ppn_array  out  ENTRIES*PPN_W  stored PPNs; entry i at bits [i*PPN_W +: PPN_W]

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all valid=0; rr_ptr=0; drop=0.
  - Outputs: lk_ready=1, rsp_valid=0, miss_valid=0, hit_bit=0, replace_entry=0, rsp_ppn/rsp_hit/rsp_err=0.
  - Tag and PPN arrays are not reset.
- FSM states: IDLE, LOOKUP, MISS, RESP.
- IDLE:
  - lk_ready = !flush.
  - On lk_valid&&lk_ready: latch lk_tag, go to LOOKUP.
- LOOKUP (exactly 1 cycle):
  - hit_bit[i] = valid[i] && tag[i]==latched tag. Tags are unique, so at most one bit is set.
  - Hit: register rsp_ppn=ppn[hit idx], rsp_hit=1, rsp_err=0; go to RESP.
  - Miss: go to MISS.
- MISS:
  - miss_valid=1 and miss_tag=latched tag, held until refill_valid.
  - On refill_valid with refill_err=0 and drop=0: write tag/PPN at replace_entry, set valid; rsp_ppn=refill_ppn, rsp_hit=0.
  - On refill_valid with refill_err=1: no install; rsp_err=1, rsp_ppn=0.
  - Either case: go to RESP next cycle.
  - refill_valid outside MISS is ignored.
- RESP:
  - rsp_valid=1; rsp_ppn/rsp_hit/rsp_err held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: go to IDLE. lk_ready rises the following cycle, so there is no same-cycle back-to-back accept.
- Latency: hit response at 2 cycles after accept. Miss response at 1 cycle after refill_valid.
- Victim selection (replace_entry, combinational from registered state):
  - If any entry is invalid, use the lowest-index invalid entry.
  - Otherwise use rr_ptr.
  - rr_ptr increments by 1, mod ENTRIES (wraps ENTRIES-1→0), only on an install made while all entries were valid.
- hit_bit is driven only in LOOKUP; 0 in all other states.
- Flush:
  - In any state, clears all valid bits at the next clock edge. rr_ptr is unchanged.
  - Flush in IDLE wins over a same-cycle lk_valid: lk_ready=0, nothing is accepted.
  - Flush in LOOKUP: the hit result computed that cycle is still returned (the entry was valid at compare time).
  - Flush in MISS, or in the same cycle as refill_valid: sets drop. The refill is returned to the requester but not installed. drop clears on entering IDLE.
- Install and flush in the same cycle: flush wins; the entry ends invalid.
- Reset asserted mid-operation: immediate return to IDLE. Any outstanding walk result arriving after reset is ignored, because the FSM is not in MISS.

Optional Feature:
- Macro: PTE_CACHE_PLRU_EN.
- Defined: the victim among all-valid entries is chosen by tree pseudo-LRU (ENTRIES-1 bits).
  - The tree is updated on every LOOKUP hit and every install, pointing away from the touched entry.
  - The tree resets to 0. Flush does not reset it.
  - rr_ptr is not instantiated.
- Undefined: round-robin rr_ptr as described above.
- The invalid-first rule applies in both builds.

Decomposition:
- Package pte_cache_pkg holds:
  - ENTRIES, TAG_W and PPN_W defaults.
  - The FSM state enum {IDLE, LOOKUP, MISS, RESP}.
  - A pte_cache_entry_t struct {valid, tag, ppn}.
- One natural sub-module: pte_cache_victim_sel. It contains the invalid-first priority encoder plus round-robin pointer or PLRU tree, and owns the PTE_CACHE_PLRU_EN switch.

Test Plan:
- Reset, then lookup tag 0x1234 -> miss_valid=1, miss_tag=0x1234. Drive refill_ppn 0xABCDE -> rsp_valid=1, rsp_hit=0, rsp_ppn=0xABCDE; entry 0 becomes valid.
- Repeat lookup of 0x1234 -> rsp_valid exactly 2 cycles after accept, rsp_hit=1, rsp_ppn=0xABCDE, hit_bit=0x01 during LOOKUP, miss_valid never asserted.
- Fill 8 distinct tags, then miss a 9th and a 10th -> installs at entries 0 then 1 (round-robin); replace_entry shows 0, then 1. With PLRU enabled, the victim is the PLRU-predicted entry after a directed hit pattern.
- Assert flush during MISS; refill_ppn 0x00042 -> response returns 0x00042; a subsequent lookup of the same tag misses; all hit_bit=0.
- Miss with refill_err=1 -> rsp_err=1, rsp_ppn=0, no entry installed; the next identical lookup misses again.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_ppn stay stable and lk_ready=0 throughout. Pulse rst_n low in MISS -> all outputs return to reset values; a late refill_valid is ignored.
